sap3_sram_arbiter: RTL and testbench

Shares the single IHP 1024x32 SRAM macro between two byte-wide requesters: the SAP-3 core (CPU port) and the host program loader/debug port (HST port). Selects one access per cycle. Drives the macro's ADDR/BM/DIN/WEN/MEN/REN and steers the addressed byte lane of DOUT back to the requester. CPU has priority, bounded by a host starvation counter. An exclusive host mode lets the loader fill memory while the core is held off.

---
 rtl/sap3_sram_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_sap3_sram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap3_sram_arbiter.sv
// Byte-wide arbiter sharing one 1024x32 SRAM macro between the SAP-3 core (CPU) and the host loader (HST).
// CPU has priority, bounded by a host starvation counter; hst_lock gives the host exclusive ownership.
module sap3_sram_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [7:0]        cpu_rdata,
    input  logic              hst_req,
    input  logic              hst_we,
    input  logic [ADDR_W-1:0] hst_addr,
    input  logic [7:0]        hst_wdata,
    output logic              hst_gnt,
    output logic              hst_rvalid,
    output logic [7:0]        hst_rdata,
    input  logic              hst_lock,
    output logic              hst_owned,
    output logic [9:0]        sram_addr,
    output logic [31:0]       sram_bm,
    output logic [31:0]       sram_din,
    output logic              sram_wen,
    output logic              sram_men,
    output logic              sram_ren,
    input  logic [31:0]       sram_dout
);

    typedef enum logic [1:0] {
        ST_SHARED = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HOST   = 2'd2
    } state_t;

    localparam logic [7:0] STARVE_LIM_C = 8'(STARVE_LIMIT);

    function automatic logic [31:0] lane_mask(input logic [1:0] lane);
        logic [31:0] m;
        case (lane)
            2'd0:    m = 32'h0000_00FF;
            2'd1:    m = 32'h0000_FF00;
            2'd2:    m = 32'h00FF_0000;
            2'd3:    m = 32'hFF00_0000;
            default: m = 32'h0000_00FF;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    state_t            state_q;
    logic              owned_q;
    logic [7:0]        starve_q, starve_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_port_q, rd_port_d;
    logic [1:0]        rd_lane_q, rd_lane_d;
    logic [9:0]        addr_q, addr_d;
    logic [31:0]       bm_q, bm_d;
    logic [31:0]       din_q, din_d;
    logic [7:0]        cpu_rdata_q, hst_rdata_q;

    logic              cpu_win_s, hst_win_s, gnt_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [7:0]        sel_wdata_s;
    logic [1:0]        lane_s;
    logic [7:0]        ret_byte_s;

    // Per-cycle winner selection; nothing is granted while reset is asserted or in DRAIN
    always_comb begin
        cpu_win_s = 1'b0;
        hst_win_s = 1'b0;
        if (!rst_n) begin
            cpu_win_s = 1'b0;
            hst_win_s = 1'b0;
        end else begin
            case (state_q)
                ST_SHARED: begin
                    if (hst_req && (starve_q >= STARVE_LIM_C)) begin
                        hst_win_s = 1'b1;
                    end else if (cpu_req) begin
                        cpu_win_s = 1'b1;
                    end else begin
                        hst_win_s = hst_req;
                    end
                end
                ST_HOST:  hst_win_s = hst_req;
                default:  hst_win_s = 1'b0;
            endcase
        end
    end

    // Winner's request fields, macro drive and next-state of the datapath registers
    always_comb begin
        gnt_s       = cpu_win_s | hst_win_s;
        sel_we_s    = hst_win_s ? hst_we    : cpu_we;
        sel_addr_s  = hst_win_s ? hst_addr  : cpu_addr;
        sel_wdata_s = hst_win_s ? hst_wdata : cpu_wdata;
        lane_s      = sel_addr_s[1:0];

        if (gnt_s) begin
            addr_d = 10'(sel_addr_s[ADDR_W-1:2]);
            bm_d   = lane_mask(lane_s);
            din_d  = {4{sel_wdata_s}};
        end else begin
            addr_d = addr_q;
            bm_d   = bm_q;
            din_d  = din_q;
        end

        rd_pend_d = gnt_s & ~sel_we_s;
        rd_port_d = hst_win_s;
        rd_lane_d = lane_s;

        // The counter is frozen while the host owns the macro
        if (state_q == ST_HOST) begin
            starve_d = starve_q;
        end else if (hst_win_s) begin
            starve_d = 8'd0;
        end else if (hst_req && (starve_q != 8'hFF)) begin
            starve_d = starve_q + 8'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // Read-return steering; rdata falls back to the held byte between rvalid pulses
    always_comb begin
        ret_byte_s = lane_byte(sram_dout, rd_lane_q);
        cpu_rvalid = rst_n & rd_pend_q & ~rd_port_q;
        hst_rvalid = rst_n & rd_pend_q &  rd_port_q;
        cpu_rdata  = cpu_rvalid ? ret_byte_s : cpu_rdata_q;
        hst_rdata  = hst_rvalid ? ret_byte_s : hst_rdata_q;
    end

    assign cpu_gnt   = cpu_win_s;
    assign hst_gnt   = hst_win_s;
    assign hst_owned = owned_q;
    assign sram_addr = addr_d;
    assign sram_bm   = bm_d;
    assign sram_din  = din_d;
    assign sram_men  = gnt_s;
    assign sram_wen  = gnt_s & sel_we_s;
    assign sram_ren  = gnt_s & ~sel_we_s;

    // Ownership FSM; DRAIN issues no grants, so any read in flight completes during it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_SHARED;
            owned_q <= 1'b0;
        end else begin
            case (state_q)
                ST_SHARED: begin
                    if (hst_lock) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        state_q <= ST_SHARED;
                    end
                    owned_q <= 1'b0;
                end
                ST_DRAIN: begin
                    state_q <= ST_HOST;
                    owned_q <= 1'b1;
                end
                ST_HOST: begin
                    if (hst_lock) begin
                        state_q <= ST_HOST;
                        owned_q <= 1'b1;
                    end else begin
                        state_q <= ST_SHARED;
                        owned_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_SHARED;
                    owned_q <= 1'b0;
                end
            endcase
        end
    end

    // Datapath registers: held macro drive, read-return tag, held read bytes, starvation count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q    <= 8'd0;
            rd_pend_q   <= 1'b0;
            rd_port_q   <= 1'b0;
            rd_lane_q   <= 2'd0;
            addr_q      <= 10'd0;
            bm_q        <= 32'd0;
            din_q       <= 32'd0;
            cpu_rdata_q <= 8'd0;
            hst_rdata_q <= 8'd0;
        end else begin
            starve_q    <= starve_d;
            rd_pend_q   <= rd_pend_d;
            rd_port_q   <= rd_port_d;
            rd_lane_q   <= rd_lane_d;
            addr_q      <= addr_d;
            bm_q        <= bm_d;
            din_q       <= din_d;
            cpu_rdata_q <= cpu_rdata;
            hst_rdata_q <= hst_rdata;
        end
    end

endmodule

// File: tb/tb_sap3_sram_arbiter.sv
// Directed self-checking bench for sap3_sram_arbiter with a behavioural 1024x32 registered-output SRAM.
module tb_sap3_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, hst_req, hst_we, hst_lock;
    logic [11:0] cpu_addr, hst_addr;
    logic [7:0]  cpu_wdata, hst_wdata;
    logic        cpu_gnt, cpu_rvalid, hst_gnt, hst_rvalid, hst_owned;
    logic [7:0]  cpu_rdata, hst_rdata;
    logic [9:0]  sram_addr;
    logic [31:0] sram_bm, sram_din;
    logic        sram_wen, sram_men, sram_ren;
    logic [31:0] sram_dout = 32'd0;

    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    logic [7:0]  lane_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [31:0] lane_masks [4] = '{32'h0000_00FF, 32'h0000_FF00, 32'h00FF_0000, 32'hFF00_0000};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_men) begin
            if (sram_wen) mem[sram_addr] <= (mem[sram_addr] & ~sram_bm) | (sram_din & sram_bm);
            if (sram_ren) sram_dout <= mem[sram_addr];
        end
    end

    sap3_sram_arbiter #(.ADDR_W(12), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .hst_req(hst_req), .hst_we(hst_we), .hst_addr(hst_addr), .hst_wdata(hst_wdata),
        .hst_gnt(hst_gnt), .hst_rvalid(hst_rvalid), .hst_rdata(hst_rdata),
        .hst_lock(hst_lock), .hst_owned(hst_owned),
        .sram_addr(sram_addr), .sram_bm(sram_bm), .sram_din(sram_din),
        .sram_wen(sram_wen), .sram_men(sram_men), .sram_ren(sram_ren),
        .sram_dout(sram_dout)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h000; cpu_wdata = 8'h00;
        hst_req = 1'b0; hst_we = 1'b0; hst_addr = 12'h000; hst_wdata = 8'h00;
        hst_lock = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, hst_gnt, cpu_rvalid, hst_rvalid} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses got %b expected 0000", {cpu_gnt, hst_gnt, cpu_rvalid, hst_rvalid});
        end
        checks++;
        if ({cpu_rdata, hst_rdata} !== 16'h0000) begin
            errors++; $display("FAIL reset_rdata got %h expected 0000", {cpu_rdata, hst_rdata});
        end
        checks++;
        if ({hst_owned, sram_men, sram_wen, sram_ren} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got %b expected 0000", {hst_owned, sram_men, sram_wen, sram_ren});
        end
        tick();
    endtask

    task automatic test_cpu_write_read;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h006; cpu_wdata = 8'hA5;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, hst_gnt} !== 2'b10) begin
            errors++; $display("FAIL wr_gnt got %b expected 10", {cpu_gnt, hst_gnt});
        end
        checks++;
        if (sram_addr !== 10'd1 || sram_bm !== 32'h00FF_0000 || sram_din !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL wr_drive got addr=%h bm=%h din=%h expected 001/00ff0000/a5a5a5a5", sram_addr, sram_bm, sram_din);
        end
        checks++;
        if ({sram_men, sram_wen, sram_ren} !== 3'b110) begin
            errors++; $display("FAIL wr_en got %b expected 110", {sram_men, sram_wen, sram_ren});
        end
        tick();
        cpu_we = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, sram_men, sram_wen, sram_ren} !== 4'b1101) begin
            errors++; $display("FAIL rd_issue got %b expected 1101", {cpu_gnt, sram_men, sram_wen, sram_ren});
        end
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, hst_rvalid} !== 2'b10 || cpu_rdata !== 8'hA5) begin
            errors++; $display("FAIL rd_return got rv=%b data=%h expected 10/a5", {cpu_rvalid, hst_rvalid}, cpu_rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'hA5) begin
            errors++; $display("FAIL rd_hold got rv=%b data=%h expected 0/a5", cpu_rvalid, cpu_rdata);
        end
        tick();
    endtask

    task automatic test_starvation;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h100; cpu_wdata = 8'h01;
        hst_req = 1'b1; hst_we = 1'b1; hst_addr = 12'h200; hst_wdata = 8'h02;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            checks++;
            if ({cpu_gnt, hst_gnt} !== (((i % 9) == 8) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL starve_seq cycle %0d got %b expected %b", i, {cpu_gnt, hst_gnt},
                                   (((i % 9) == 8) ? 2'b01 : 2'b10));
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_host_lanes;
        hst_req = 1'b1; hst_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hst_addr = 12'(i); hst_wdata = lane_bytes[i];
            @(negedge clk);
            checks++;
            if (hst_gnt !== 1'b1 || sram_bm !== lane_masks[i] || sram_wen !== 1'b1) begin
                errors++; $display("FAIL hst_wr lane %0d got gnt=%b bm=%h expected 1/%h", i, hst_gnt, sram_bm, lane_masks[i]);
            end
            tick();
        end
        hst_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) hst_addr = 12'(i);
            else hst_req = 1'b0;
            @(negedge clk);
            if (i < 4) begin
                checks++;
                if (hst_gnt !== 1'b1 || sram_ren !== 1'b1) begin
                    errors++; $display("FAIL hst_rd_gnt %0d got gnt=%b ren=%b expected 1/1", i, hst_gnt, sram_ren);
                end
            end
            if (i > 0) begin
                checks++;
                if (hst_rvalid !== 1'b1 || hst_rdata !== lane_bytes[i-1]) begin
                    errors++; $display("FAIL hst_rd_data %0d got rv=%b data=%h expected 1/%h", i - 1, hst_rvalid, hst_rdata, lane_bytes[i-1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_lock;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h006; hst_lock = 1'b1;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, hst_owned} !== 2'b10) begin
            errors++; $display("FAIL lock_issue got gnt/owned=%b expected 10", {cpu_gnt, hst_owned});
        end
        tick();
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA5 || cpu_gnt !== 1'b0) begin
            errors++; $display("FAIL lock_drain got rv=%b data=%h gnt=%b expected 1/a5/0", cpu_rvalid, cpu_rdata, cpu_gnt);
        end
        tick();
        hst_req = 1'b1; hst_we = 1'b1; hst_addr = 12'h300; hst_wdata = 8'h77;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({hst_owned, cpu_gnt, hst_gnt} !== 3'b101) begin
                errors++; $display("FAIL lock_host %0d got owned/cgnt/hgnt=%b expected 101", i, {hst_owned, cpu_gnt, hst_gnt});
            end
            tick();
        end
        hst_req = 1'b0; hst_lock = 1'b0;
        @(negedge clk);
        checks++;
        if ({hst_owned, cpu_gnt} !== 2'b10) begin
            errors++; $display("FAIL lock_release got owned/gnt=%b expected 10", {hst_owned, cpu_gnt});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({hst_owned, cpu_gnt} !== 2'b01) begin
            errors++; $display("FAIL lock_shared got owned/gnt=%b expected 01", {hst_owned, cpu_gnt});
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_inflight;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h006;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1) begin
            errors++; $display("FAIL rst_rd_issue got %b expected 1", cpu_gnt);
        end
        tick();
        cpu_req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, hst_rvalid} !== 2'b00) begin
            errors++; $display("FAIL rst_drop got %b expected 00", {cpu_rvalid, hst_rvalid});
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({cpu_rdata, hst_rdata} !== 16'h0000 || {cpu_rvalid, hst_rvalid, hst_owned} !== 3'b000) begin
            errors++; $display("FAIL rst_outs got rdata=%h rv/owned=%b expected 0000/000", {cpu_rdata, hst_rdata},
                               {cpu_rvalid, hst_rvalid, hst_owned});
        end
        checks++;
        if (sram_addr !== 10'd0 || sram_bm !== 32'd0 || {sram_men, sram_wen, sram_ren} !== 3'b000) begin
            errors++; $display("FAIL rst_sram got addr=%h bm=%h en=%b expected 000/0/000", sram_addr, sram_bm,
                               {sram_men, sram_wen, sram_ren});
        end
        tick();
    endtask

    task automatic test_idle_oob;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({sram_men, sram_wen, sram_ren} !== 3'b000) begin
                errors++; $display("FAIL idle_en %0d got %b expected 000", i, {sram_men, sram_wen, sram_ren});
            end
            tick();
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'hFFF; cpu_wdata = 8'h5C;
        @(negedge clk);
        checks++;
        if (sram_addr !== 10'h3FF || sram_bm !== 32'hFF00_0000 || sram_wen !== 1'b1) begin
            errors++; $display("FAIL oob_drive got addr=%h bm=%h wen=%b expected 3ff/ff000000/1", sram_addr, sram_bm, sram_wen);
        end
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (sram_addr !== 10'h3FF || sram_bm !== 32'hFF00_0000 || sram_din !== 32'h5C5C_5C5C || sram_men !== 1'b0) begin
            errors++; $display("FAIL oob_hold got addr=%h bm=%h din=%h men=%b expected 3ff/ff000000/5c5c5c5c/0",
                               sram_addr, sram_bm, sram_din, sram_men);
        end
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0;
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5C) begin
            errors++; $display("FAIL oob_read got rv=%b data=%h expected 1/5c", cpu_rvalid, cpu_rdata);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_cpu_write_read();
        test_starvation();
        test_host_lanes();
        test_lock();
        test_reset_inflight();
        test_idle_oob();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
